// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and state encoding for the cache miss handler
package cache_pkg;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFFSET_W + 1;
  localparam int BLOCK_BYTES = 2 * WORDS_PER_BLOCK;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: cache-side and memory-side signals of the miss handler
interface cache_fill_fsm_if;
  import cache_pkg::*;
  logic miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic fsm_busy;
  logic mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic write_data_array;
  logic write_tag_array;
  logic [OFFSET_W-1:0] word_offset;
  logic [DATA_W-1:0] fill_data;
  modport master(
    input miss_detected, miss_address, mem_data_valid, mem_data,
    output fsm_busy, mem_read_en, mem_addr, write_data_array, write_tag_array, word_offset, fill_data
  );
  modport slave(
    output miss_detected, miss_address, mem_data_valid, mem_data,
    input fsm_busy, mem_read_en, mem_addr, write_data_array, write_tag_array, word_offset, fill_data
  );
endinterface

// File: rtl/fill_counter.sv
// fill_counter: up-counter with sync clear, enable and terminal-count flag
module fill_counter #(
  parameter int W = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  // count enabled cycles, cleared by reset or clear
  always_ff @(posedge clk) cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;
  // terminal count reached
  always_comb tc = cnt == W'(MAX);
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a full block from pipelined memory on a cache miss
module cache_fill_fsm
  import cache_pkg::*;
(
  input logic clk,
  input logic rst,
  cache_fill_fsm_if.master bus
);
  state_t state;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0] issue_cnt, recv_cnt;
  logic issue_done, recv_done, fill, wr, last;
  fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_issue (
    .clk(clk), .rst(rst), .clr(!fill), .en(fill && !issue_done), .cnt(issue_cnt), .tc(issue_done)
  );
  fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_recv (
    .clk(clk), .rst(rst), .clr(!fill), .en(wr && !recv_done), .cnt(recv_cnt), .tc(recv_done)
  );
  // outputs are decoded from state, counters and the current inputs
  always_comb begin
    fill = state == FILL;
    wr = fill && bus.mem_data_valid;
    last = wr && recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
    bus.fsm_busy = fill || bus.miss_detected;
    bus.mem_read_en = fill && !issue_done;
    bus.mem_addr = !fill ? '0 : issue_done ? base_addr : base_addr + (ADDR_W'(issue_cnt) << 1);
    bus.write_data_array = wr;
    bus.write_tag_array = last;
    bus.word_offset = wr ? recv_cnt[OFFSET_W-1:0] : '0;
    bus.fill_data = fill ? bus.mem_data : '0;
  end
  // latch the aligned block base on a miss; return to idle after the tag write
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      base_addr <= '0;
    end else if (!fill && bus.miss_detected) begin
      state <= FILL;
      base_addr <= bus.miss_address & ~ADDR_W'(BLOCK_BYTES - 1);
    end else if (last) state <= IDLE;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench with a latency-modelled memory
module tb_cache_fill_fsm;
  import cache_pkg::*;
  typedef struct {int cyc; logic [15:0] addr;} rd_t;
  typedef struct {int cyc; logic [2:0] off; logic [15:0] data; logic tag;} wr_t;
  typedef struct {int cyc; logic [15:0] data;} ret_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  cache_fill_fsm_if bus();
  cache_fill_fsm dut(.clk(clk), .rst(rst), .bus(bus.master));
  rd_t rd_q[$];
  wr_t wr_q[$];
  ret_t mem_q[$];
  int cyc = 0, n_cmp = 0, n_fail = 0, n_acc = 0, lat = 4, last_ret = 0;
  bit gaps = 0, junk = 0, active = 0;
  logic [15:0] salt, base;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ salt;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_ok(input string name, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: condition false at cycle %0d", name, cyc);
    end
  endtask

  // memory: returns scheduled words, or junk data while idle when asked
  initial begin
    bus.mem_data_valid = 0;
    bus.mem_data = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
        bus.mem_data_valid = 1;
        bus.mem_data = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        bus.mem_data_valid = junk;
        bus.mem_data = junk ? 16'hBEEF : 16'($urandom);
      end
    end
  end

  // memory request capture, reference model and monitor
  always @(negedge clk) begin
    int r;
    bit acc;
    rd_t re;
    wr_t we;
    if (bus.mem_read_en) begin
      r = cyc + lat;
      if (gaps && last_ret + 1 + int'($urandom_range(0, 1)) > r) r = last_ret + 1 + int'($urandom_range(0, 1));
      if (r <= last_ret) r = last_ret + 1;
      last_ret = r;
      mem_q.push_back('{r, mem_word(bus.mem_addr)});
    end
    if (rst) begin
      rd_q.delete();
      wr_q.delete();
      active = 0;
    end else begin
      acc = !active && bus.miss_detected;
      check("fsm_busy", 64'(bus.fsm_busy), 64'(active || bus.miss_detected));
      if (!active)
        check("idle_outputs", 64'({bus.mem_read_en, bus.mem_addr, bus.write_data_array,
              bus.write_tag_array, bus.word_offset, bus.fill_data}), 64'(0));
      else begin
        if (bus.mem_read_en) begin
          check_ok("read_expected", rd_q.size() > 0);
          if (rd_q.size() > 0) begin
            re = rd_q.pop_front();
            check("read_cycle", 64'(cyc), 64'(re.cyc));
            check("read_addr", 64'(bus.mem_addr), 64'(re.addr));
          end
        end else check("hold_addr", 64'(bus.mem_addr), 64'(base));
        if (bus.write_data_array) begin
          check_ok("write_expected", wr_q.size() > 0);
          if (wr_q.size() > 0) begin
            we = wr_q.pop_front();
            if (we.cyc >= 0) check("write_cycle", 64'(cyc), 64'(we.cyc));
            check("word_offset", 64'(bus.word_offset), 64'(we.off));
            check("fill_data", 64'(bus.fill_data), 64'(we.data));
            check("write_tag", 64'(bus.write_tag_array), 64'(we.tag));
            if (we.tag) active = 0;
          end
        end else check("tag_without_data", 64'(bus.write_tag_array), 64'(0));
      end
      if (acc) begin
        active = 1;
        n_acc++;
        base = bus.miss_address & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
          rd_q.push_back('{cyc + 1 + i, 16'(base + 16'(2 * i))});
          wr_q.push_back('{gaps ? -1 : cyc + 1 + i + lat, 3'(i), mem_word(16'(base + 16'(2 * i))), i == 7});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || mem_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    check_ok("fill_timeout", n < 300);
    tick();
  endtask

  task automatic fill(input logic [15:0] a, input bit g, input int l);
    gaps = g;
    lat = l;
    bus.miss_address = a;
    bus.miss_detected = 1;
    tick();
    bus.miss_detected = 0;
    bus.miss_address = 16'($urandom);
    wait_idle();
  endtask

  initial begin
    int start, n;
    salt = 16'($urandom);
    bus.miss_detected = 0;
    bus.miss_address = 0;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    fill(16'h1234, 0, 4);
    junk = 1;
    repeat (6) tick();
    junk = 0;
    tick();
    start = n_acc;
    n = 0;
    bus.miss_address = 16'h2468;
    bus.miss_detected = 1;
    tick();
    bus.miss_address = 16'h7ABC;
    while (n_acc < start + 2 && n < 300) begin
      tick();
      n++;
    end
    check_ok("held_miss_refill", n_acc == start + 2);
    bus.miss_detected = 0;
    wait_idle();
    gaps = 0;
    lat = 4;
    bus.miss_address = 16'h0456;
    bus.miss_detected = 1;
    tick();
    bus.miss_detected = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_idle();
    fill(16'hFFFE, 0, 4);
    fill(16'h5A5A, 1, 4);
    for (int k = 0; k < 20; k++) begin
      fill(16'($urandom), 1'($urandom), int'($urandom_range(1, 6)));
      junk = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      junk = 0;
      tick();
    end
    check_ok("queues_drained", rd_q.size() == 0 && wr_q.size() == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
